// File: rtl/riscv_r_pkg.sv
// Shared encodings for the RV32 R-type sequencer and its decoder.
package riscv_r_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_NOP   = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/riscv_r_decode.sv
// Combinational R-type decoder: splits an instruction word into register
// indices and an ALU operation, and classifies it as legal add/sub or zero.
module riscv_r_decode
    import riscv_r_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [4:0]  o_rs1_c,
    output logic [4:0]  o_rs2_c,
    output logic [4:0]  o_rd_c,
    output logic [3:0]  o_alu_op_c,
    output logic        o_legal_c,
    output logic        o_is_zero_c
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode    = i_ir[6:0];
    assign w_funct3    = i_ir[14:12];
    assign w_funct7    = i_ir[31:25];
    assign o_rd_c      = i_ir[11:7];
    assign o_rs1_c     = i_ir[19:15];
    assign o_rs2_c     = i_ir[24:20];
    assign o_is_zero_c = (i_ir == 32'h0);

    // Only the add/sub pair of the OP major opcode is supported.
    always_comb begin
        o_alu_op_c = ALU_NOP;
        o_legal_c  = 1'b0;
        if (w_opcode == OPC_RTYPE && w_funct3 == F3_ADDSUB) begin
            if (w_funct7 == F7_ADD) begin
                o_alu_op_c = ALU_ADD;
                o_legal_c  = 1'b1;
            end else if (w_funct7 == F7_SUB) begin
                o_alu_op_c = ALU_SUB;
                o_legal_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_r_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the R-type datapath.
// Instructions arrive one byte per handshake from a byte-wide instruction memory.
module riscv_r_seq
    import riscv_r_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop_req,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [7:0]         imem_rdata,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [3:0]         alu_op,
    output logic               rf_we,
    output logic [IMEM_AW-1:0] pc,
    output logic               busy,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    seq_state_t         r_state;
    logic [31:0]        r_ir;
    logic [1:0]         r_byte_cnt;
    logic [IMEM_AW-1:0] r_pc;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic               r_imem_req;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [4:0]         r_rd;
    logic [3:0]         r_alu_op;
    logic               r_rf_we;
    logic               r_busy;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;

    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic [4:0]         w_rd;
    logic [3:0]         w_alu_op;
    logic               w_legal;
    logic               w_is_zero;

    riscv_r_decode u_decode (
        .i_ir        (r_ir),
        .o_rs1_c     (w_rs1),
        .o_rs2_c     (w_rs2),
        .o_rd_c      (w_rd),
        .o_alu_op_c  (w_alu_op),
        .o_legal_c   (w_legal),
        .o_is_zero_c (w_is_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ir        <= 32'h0;
            r_byte_cnt  <= 2'd0;
            r_pc        <= '0;
            r_imem_addr <= '0;
            r_imem_req  <= 1'b0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_alu_op    <= ALU_NOP;
            r_rf_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_illegal   <= 1'b0;
            r_retired   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_pc        <= '0;
                        r_imem_addr <= '0;
                        r_byte_cnt  <= 2'd0;
                        r_retired   <= '0;
                        r_illegal   <= 1'b0;
                        r_imem_req  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                // Little-endian byte assembly; the request stays up across wait cycles.
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir[{r_byte_cnt, 3'b000} +: 8] <= imem_rdata;
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        r_imem_addr <= r_imem_addr + IMEM_AW'(1);
                        if (r_byte_cnt == 2'd3) begin
                            r_state    <= S_DECODE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                S_DECODE: begin
                    r_rs1 <= w_rs1;
                    r_rs2 <= w_rs2;
                    r_rd  <= w_rd;
                    if (w_is_zero) begin
                        r_state <= S_HALT;
                        r_busy  <= 1'b0;
                    end else if (w_legal) begin
                        r_state  <= S_EXEC;
                        r_alu_op <= w_alu_op;
                    end else begin
                        r_state   <= S_HALT;
                        r_busy    <= 1'b0;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                    r_rf_we <= (r_rd != 5'd0);
                end
                // Retire; x0 is never written but still counts as retired.
                S_WB: begin
                    r_rf_we   <= 1'b0;
                    r_alu_op  <= ALU_NOP;
                    r_pc      <= r_pc + IMEM_AW'(4);
                    r_retired <= r_retired + CNT_W'(1);
                    if (stop_req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= S_FETCH;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc + IMEM_AW'(4);
                        r_byte_cnt  <= 2'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign alu_op    = r_alu_op;
    assign rf_we     = r_rf_we;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign illegal   = r_illegal;
    assign retired   = r_retired;

endmodule
